apb_mem_slave_ws: RTL and testbench
===================================

Name: apb_mem_slave_ws

Overview:
Parametrised APB memory slave: next generation of the team's single-cycle APB slave memory. Adds generic data width, a depth that need not be a power of two, a configurable number of access-phase wait states, and PSLVERR on out-of-range addresses. Sits behind the APB decoder as one Psel-selected peripheral and serves as scratch RAM and as a wait-state test target for the master.

Parameters:
ADDR_WIDTH, 8, word-address width of Paddr
DATA_WIDTH, 32, data width; must be a multiple of 8 and at least 8
DEPTH, 200, number of words; 1..2**ADDR_WIDTH
WAIT_CYCLES, 2, Pready-low cycles inserted per access phase; 0..15
PROT_LIMIT, 16, words [0..PROT_LIMIT-1] are write-protected (used only with the optional feature)

Ports:
Pclk  in  1  clock; all state changes on the rising edge
Preset  in  1  asynchronous, active-high reset
Psel  in  1  slave select
Penable  in  1  access-phase indicator
Pwrite  in  1  1 = write, 0 = read
Pstrb  in  DATA_WIDTH/8  byte write strobes; bit i enables byte lane i
Paddr  in  ADDR_WIDTH  word address
Pwdata  in  DATA_WIDTH  write data
Prdata  out  DATA_WIDTH  read data
Pready  out  1  transfer complete
Pslverr  out  1  transfer error; qualified by Pready

Behaviour:
- Reset: Preset=1 forces state IDLE, counter 0, read register 0, so Prdata=0, Pready=0, Pslverr=0. Memory contents are not reset.
- FSM states: IDLE and ACCESS. Counter cnt is $clog2(WAIT_CYCLES+1) bits wide, minimum 1.
- IDLE:
  - Psel=1 (Penable either value) -> ACCESS, cnt<=WAIT_CYCLES.
  - Psel=1 with Penable=1 in IDLE is a master protocol slip. It is tolerated and treated as the setup cycle.
- ACCESS:
  - Psel=0 -> IDLE. Access abandoned; no write occurs.
  - Psel=1, Penable=0 -> stay ACCESS, cnt<=WAIT_CYCLES (new setup).
  - Psel=1, Penable=1, cnt!=0 -> cnt<=cnt-1, Pready=0.
  - Psel=1, Penable=1, cnt==0 -> completion cycle. Next state IDLE.
- Pready is combinational: (state==ACCESS) && Psel && Penable && (cnt==0). Access phase therefore lasts exactly WAIT_CYCLES+1 cycles.
- Range error: addr_bad = (Paddr >= DEPTH). Pslverr = Pready && addr_bad. Otherwise Pslverr=0.
- Write: performed only at the completion edge, when Pwrite=1 and addr_bad=0.
  - Byte lane i is updated iff Pstrb[i]=1.
  - Pstrb=0 completes normally with no memory change.
- Read:
  - The read register loads mem[Paddr] on every rising edge where Psel=1 and Pwrite=0. It loads 0 if addr_bad.
  - Prdata = (Pready && !Pwrite) ? read register : 0.
  - Read data reflects memory as of the edge before completion, so latency from setup is WAIT_CYCLES+1 cycles.
- Back-to-back: a transfer may start in the cycle after completion (Psel held, Penable=0). That cycle is the new setup.
- Write followed immediately by a read of the same address returns the new data; the write edge precedes the read setup edge.
- Reset asserted mid-access: outputs drop to 0 immediately (asynchronous). Any pending write is lost.
- Pclk-to-output paths are registered state plus simple gating; there are no combinational paths from Pwdata to Prdata.

Optional Feature:
APB_WPROT_EN:
- Defined: a write with Paddr < PROT_LIMIT completes with Pslverr=1 and the memory is not modified. Reads of protected words are unaffected.
- Undefined: PROT_LIMIT is ignored and all in-range words are writable.

Test Plan:
- Reset and idle: Preset=1 for 3 cycles, then release with Psel=0 -> Prdata=0, Pready=0, Pslverr=0 throughout.
- Write then read, WAIT_CYCLES=2: write 0xDEADBEEF, Pstrb=4'hF, Paddr=5, then read Paddr=5.
  - Pready is low for 2 access cycles and high on the 3rd.
  - Read completes with Prdata=0xDEADBEEF, Pslverr=0.
- Byte strobes: word 7=0x11223344, then write 0xAABBCCDD with Pstrb=4'b0101 -> read returns 0x11BB33DD.
- Out of range, DEPTH=200: write at Paddr=200 -> Pready with Pslverr=1. Read at Paddr=255 -> Prdata=0, Pslverr=1. Word 199 remains writable and readable.
- Abort and reset mid-access:
  - Drop Psel during the wait of a write to Paddr=9 -> word 9 unchanged.
  - Assert Preset during a read wait -> Pready=0 and Prdata=0 at once; the next full access works.
- With APB_WPROT_EN, PROT_LIMIT=16: write 0x55 to Paddr=3 -> Pslverr=1 and a read returns the old value. Write to Paddr=16 -> Pslverr=0 and data is stored.

Source files
------------

// File: rtl/apb_mem_slave_ws.sv
// APB memory slave with configurable access-phase wait states, byte strobes and PSLVERR on out-of-range words.
// Optional write protection of words [0..PROT_LIMIT-1] is enabled by defining APB_WPROT_EN.
module apb_mem_slave_ws #(
   parameter int unsigned ADDR_WIDTH  = 8,
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned DEPTH       = 200,
   parameter int unsigned WAIT_CYCLES = 2,
   parameter int unsigned PROT_LIMIT  = 16
) (
   input  logic                    Pclk,
   input  logic                    Preset,
   input  logic                    Psel,
   input  logic                    Penable,
   input  logic                    Pwrite,
   input  logic [DATA_WIDTH/8-1:0] Pstrb,
   input  logic [ADDR_WIDTH-1:0]   Paddr,
   input  logic [DATA_WIDTH-1:0]   Pwdata,
   output logic [DATA_WIDTH-1:0]   Prdata,
   output logic                    Pready,
   output logic                    Pslverr
);

   localparam int unsigned STRB_W = DATA_WIDTH / 8;
   localparam int unsigned CNT_W  = (WAIT_CYCLES == 0) ? 1 : $clog2(WAIT_CYCLES + 1);
   localparam logic [CNT_W-1:0]    CNT_INIT = CNT_W'(WAIT_CYCLES);
   // Compare in ADDR_WIDTH+1 bits so DEPTH == 2**ADDR_WIDTH is representable.
   localparam logic [ADDR_WIDTH:0] DEPTH_L  = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] PROT_L   = (ADDR_WIDTH + 1)'(PROT_LIMIT);
`ifdef APB_WPROT_EN
   localparam bit WPROT = 1'b1;
`else
   localparam bit WPROT = 1'b0;
`endif

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_e;

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic [DATA_WIDTH-1:0]   mem_q [0:DEPTH-1];

   logic addr_bad;
   logic prot_hit;
   logic done;
   logic wr_en;

   assign addr_bad = ({1'b0, Paddr} >= DEPTH_L);
   assign prot_hit = WPROT && Pwrite && ({1'b0, Paddr} < PROT_L);
   assign done     = (state_q == ACCESS) && Psel && Penable && (cnt_q == '0);
   assign wr_en    = done && Pwrite && !addr_bad && !prot_hit;

   assign Pready  = done;
   assign Pslverr = done && (addr_bad || prot_hit);
   assign Prdata  = (done && !Pwrite) ? rdata_q : '0;

   // State and wait counter register
   always_ff @(posedge Pclk or posedge Preset) begin
      if (Preset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
      end
   end

   // Next-state, wait countdown and read capture
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      unique case (state_q)
         IDLE: begin
            // A setup with Penable already high is accepted as a plain setup.
            if (Psel) begin
               state_d = ACCESS;
               cnt_d   = CNT_INIT;
            end
         end
         ACCESS: begin
            if (!Psel) begin
               state_d = IDLE;
            end else if (!Penable) begin
               cnt_d = CNT_INIT;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (Psel && !Pwrite) begin
         rdata_d = addr_bad ? '0 : mem_q[Paddr];
      end
   end

   // Storage array is deliberately not reset
   always_ff @(posedge Pclk) begin
      if (wr_en) begin
         for (int i = 0; i < STRB_W; i++) begin
            if (Pstrb[i]) begin
               mem_q[Paddr][8*i +: 8] <= Pwdata[8*i +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_apb_mem_slave_ws.sv
// Self-checking bench for apb_mem_slave_ws: directed cases plus random traffic against a word-array model.
module tb_apb_mem_slave_ws;

   localparam int unsigned AW    = 8;
   localparam int unsigned DW    = 32;
   localparam int unsigned SW    = DW / 8;
   localparam int unsigned DEPTH = 200;
   localparam int unsigned WAITC = 2;
   localparam int unsigned PLIM  = 16;

   logic          Pclk = 1'b0;
   logic          Preset;
   logic          Psel, Penable, Pwrite;
   logic [SW-1:0] Pstrb;
   logic [AW-1:0] Paddr;
   logic [DW-1:0] Pwdata;
   logic [DW-1:0] Prdata;
   logic          Pready, Pslverr;

   int checks   = 0;
   int failures = 0;

   logic [DW-1:0] ref_mem [DEPTH];

   apb_mem_slave_ws #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH),
      .WAIT_CYCLES(WAITC), .PROT_LIMIT(PLIM)
   ) dut (
      .Pclk(Pclk), .Preset(Preset), .Psel(Psel), .Penable(Penable),
      .Pwrite(Pwrite), .Pstrb(Pstrb), .Paddr(Paddr), .Pwdata(Pwdata),
      .Prdata(Prdata), .Pready(Pready), .Pslverr(Pslverr)
   );

   always #5 Pclk = ~Pclk;

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic idle_cycle();
      @(posedge Pclk); #1;
      Psel = 1'b0; Penable = 1'b0;
      @(negedge Pclk);
      chk("idle_pready", DW'(Pready), '0);
      chk("idle_prdata", Prdata, '0);
   endtask

   // One APB transfer; returns at the negedge of the completion cycle.
   task automatic xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                       input logic [SW-1:0] st, output logic [DW-1:0] rd, output logic err,
                       output int waits, output bit done);
      @(posedge Pclk); #1;
      Psel = 1'b1; Penable = 1'b0; Pwrite = wr; Paddr = addr; Pwdata = wd; Pstrb = st;
      @(posedge Pclk); #1;
      Penable = 1'b1;
      waits = 0; done = 1'b0; rd = '0; err = 1'b0;
      for (int c = 0; c < 20 && !done; c++) begin
         @(negedge Pclk);
         if (Pready) begin
            rd = Prdata; err = Pslverr; done = 1'b1;
         end else begin
            waits++;
            @(posedge Pclk); #1;
         end
      end
   endtask

   // Transfer checked against the model; model updated from the protocol rules.
   task automatic run(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                      input logic [SW-1:0] st, output logic [DW-1:0] rd);
      logic          err, bad, prot, exp_err;
      logic [DW-1:0] exp_rd;
      int            waits;
      bit            done;
      bad  = (int'(addr) >= DEPTH);
`ifdef APB_WPROT_EN
      prot = wr && (int'(addr) < PLIM);
`else
      prot = 1'b0;
`endif
      exp_err = bad || prot;
      exp_rd  = (wr || bad) ? '0 : ref_mem[addr];
      xfer(wr, addr, wd, st, rd, err, waits, done);
      chk("timeout", DW'(done), DW'(1));
      chk("wait_count", DW'(waits), DW'(WAITC));
      chk("pslverr", DW'(err), DW'(exp_err));
      chk(wr ? "prdata_on_write" : "prdata", rd, exp_rd);
      if (wr && !bad && !prot) begin
         for (int i = 0; i < int'(SW); i++)
            if (st[i]) ref_mem[addr][8*i +: 8] = wd[8*i +: 8];
      end
   endtask

   initial begin
      logic [DW-1:0] rd, old9;
      bit            seen;
      Preset = 1'b1; Psel = 1'b0; Penable = 1'b0; Pwrite = 1'b0;
      Pstrb = '0; Paddr = '0; Pwdata = '0;

      for (int i = 0; i < 3; i++) begin
         @(negedge Pclk);
         chk("rst_prdata", Prdata, '0);
         chk("rst_pready", DW'(Pready), '0);
         chk("rst_pslverr", DW'(Pslverr), '0);
      end
      @(posedge Pclk); #1;
      Preset = 1'b0;
      for (int i = 0; i < 3; i++) idle_cycle();

      for (int a = 0; a < int'(DEPTH); a++) run(1'b1, AW'(a), DW'($urandom), '1, rd);

      run(1'b1, AW'(5), 32'hDEADBEEF, 4'hF, rd);
      run(1'b0, AW'(5), '0, '0, rd);
      chk("rd_deadbeef", rd, 32'hDEADBEEF);

      run(1'b1, AW'(7), 32'h11223344, 4'hF, rd);
      run(1'b1, AW'(7), 32'hAABBCCDD, 4'b0101, rd);
      run(1'b0, AW'(7), '0, '0, rd);
      chk("rd_strobe", rd, 32'h11BB33DD);
      run(1'b1, AW'(7), 32'hFFFFFFFF, 4'b0000, rd);
      run(1'b0, AW'(7), '0, '0, rd);
      chk("rd_strobe_zero", rd, 32'h11BB33DD);

      run(1'b1, AW'(200), 32'h12345678, 4'hF, rd);
      run(1'b0, AW'(255), '0, '0, rd);
      run(1'b1, AW'(199), 32'hA5A5_5A5A, 4'hF, rd);
      run(1'b0, AW'(199), '0, '0, rd);
      chk("rd_199", rd, 32'hA5A5_5A5A);

      // Abandon a write to word 9 during its wait states.
      old9 = ref_mem[9];
      idle_cycle();
      @(posedge Pclk); #1;
      Psel = 1'b1; Penable = 1'b0; Pwrite = 1'b1; Paddr = AW'(9); Pwdata = 32'hCAFE0000; Pstrb = 4'hF;
      @(posedge Pclk); #1;
      Penable = 1'b1;
      @(negedge Pclk);
      chk("abort_pready", DW'(Pready), '0);
      idle_cycle();
      run(1'b0, AW'(9), '0, '0, rd);
      chk("abort_word9", rd, old9);

      // Reset while a read is presenting data.
      @(posedge Pclk); #1;
      Psel = 1'b1; Penable = 1'b0; Pwrite = 1'b0; Paddr = AW'(5);
      @(posedge Pclk); #1;
      Penable = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge Pclk);
         if (Pready) seen = 1'b1;
      end
      chk("pre_rst_ready", DW'(seen), DW'(1));
      chk("pre_rst_prdata", Prdata, 32'hDEADBEEF);
      #1 Preset = 1'b1;
      #1;
      chk("midrst_pready", DW'(Pready), '0);
      chk("midrst_prdata", Prdata, '0);
      chk("midrst_pslverr", DW'(Pslverr), '0);
      Psel = 1'b0; Penable = 1'b0;
      @(posedge Pclk); @(posedge Pclk); #1;
      Preset = 1'b0;
      run(1'b0, AW'(5), '0, '0, rd);
      chk("post_rst_read", rd, 32'hDEADBEEF);

`ifdef APB_WPROT_EN
      old9 = ref_mem[3];
      run(1'b1, AW'(3), 32'h55, 4'hF, rd);
      run(1'b0, AW'(3), '0, '0, rd);
      chk("prot_word3", rd, old9);
      run(1'b1, AW'(16), 32'h0000_0055, 4'hF, rd);
      run(1'b0, AW'(16), '0, '0, rd);
      chk("prot_word16", rd, 32'h0000_0055);
`endif

      for (int n = 0; n < 300; n++) begin
         logic          wr;
         logic [AW-1:0] a;
         wr = 1'($urandom_range(0, 1));
         a  = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(DEPTH, 255)) : AW'($urandom_range(0, DEPTH - 1));
         run(wr, a, DW'($urandom), SW'($urandom), rd);
         if ($urandom_range(0, 2) == 0) idle_cycle();
      end

      idle_cycle();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
